phy_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one TX PHY lane between `NUM_REQ` flit sources (switch output ports / virtual channels).
- Sits between the switch egress and the TX PHY encoder:
  - Captures one flit per cycle from the granted requester into a single output register.
  - Drives the PHY-side `data_ready`/`flit` handshake.
  - Honours the PHY's `buffer_full` backpressure.

---
 rtl/chiplet_types_pkg.sv | 23 ++
 rtl/phy_tx_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/phy_tx_arbiter.sv | 111 +++++++++++
 tb/tb_phy_tx_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: flit format plus the TX PHY arbiter pointer/state types.
package chiplet_types_pkg;

  typedef logic [31:0] flit_t;

  localparam int unsigned PHY_ARB_MAX_REQ = 8;

  typedef logic [2:0] arb_ptr_t;

  typedef enum logic {
    StEmpty,
    StFull
  } phy_arb_state_e;

  // Advance a round-robin pointer past the granted requester, wrapping at num_req.
  function automatic arb_ptr_t arb_ptr_inc(arb_ptr_t ptr, int unsigned num_req);
    if (32'(ptr) + 32'd1 >= num_req) begin
      return '0;
    end
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/phy_tx_arbiter_if.sv
// Requester and PHY-side signal group of the TX arbiter; master is the arbiter, slave its
// environment (requesters plus PHY encoder).
interface phy_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import chiplet_types_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  flit_t              req_flit [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic               data_ready;
  flit_t              flit;
  logic               buffer_full;
  logic [7:0]         stall_cnt;
  logic               stall_err;

  modport master (
    input  req_valid, req_flit, buffer_full,
    output req_ready, data_ready, flit, stall_cnt, stall_err
  );

  modport slave (
    output req_valid, req_flit, buffer_full,
    input  req_ready, data_ready, flit, stall_cnt, stall_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr, else lowest set request.
module rr_arbiter
  import chiplet_types_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  arb_ptr_t           i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_gnt_hi;
  logic [NUM_REQ-1:0] w_gnt_lo;

  assign w_hi = i_req & ({NUM_REQ{1'b1}} << i_ptr);

  // Scanning downward lets the lowest set bit win in each half.
  always_comb begin
    w_gnt_hi = '0;
    w_gnt_lo = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (w_hi[i]) begin
        w_gnt_hi    = '0;
        w_gnt_hi[i] = 1'b1;
      end
      if (i_req[i]) begin
        w_gnt_lo    = '0;
        w_gnt_lo[i] = 1'b1;
      end
    end
  end

  assign o_gnt = (|w_hi) ? w_gnt_hi : w_gnt_lo;

endmodule

// File: rtl/phy_tx_arbiter.sv
// Round-robin arbiter sharing one TX PHY lane between NUM_REQ flit sources.
// Optional stall counter/timeout built only when PHY_TX_ARB_STALL_EN is defined.
module phy_tx_arbiter
  import chiplet_types_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_STALL = 255
) (
  input logic             CLK,
  input logic             nRST,
  phy_tx_arbiter_if.master arb_bus
);

  if (NUM_REQ < 2 || NUM_REQ > PHY_ARB_MAX_REQ || MAX_STALL > 255) begin : g_param_check
    $error("phy_tx_arbiter: illegal NUM_REQ or MAX_STALL");
  end

  phy_arb_state_e     r_state;
  phy_arb_state_e     w_state_next;
  arb_ptr_t           r_rr_ptr;
  arb_ptr_t           w_gidx;
  flit_t              r_flit;
  flit_t              w_sel_flit;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_transfer;
  logic               w_load;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .i_req(arb_bus.req_valid),
    .i_ptr(r_rr_ptr),
    .o_gnt(w_gnt)
  );

  // nRST gates load so no requester is acked for a flit that reset would drop.
  always_comb begin
    w_transfer   = (r_state == StFull) && !arb_bus.buffer_full;
    w_load       = nRST && ((r_state == StEmpty) || w_transfer) && (|arb_bus.req_valid);
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_load) w_state_next = StFull;
      StFull:  if (w_transfer && !w_load) w_state_next = StEmpty;
      default: w_state_next = StEmpty;
    endcase
  end

  always_comb begin
    w_sel_flit = '0;
    w_gidx     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_gnt[i]) begin
        w_sel_flit = w_sel_flit | arb_bus.req_flit[i];
        w_gidx     = arb_ptr_t'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= StEmpty;
      r_flit   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_flit   <= w_sel_flit;
        r_rr_ptr <= arb_ptr_inc(w_gidx, NUM_REQ);
      end
    end
  end

  assign arb_bus.req_ready  = w_load ? w_gnt : '0;
  assign arb_bus.data_ready = (r_state == StFull);
  assign arb_bus.flit       = r_flit;

`ifdef PHY_TX_ARB_STALL_EN
  logic [7:0] r_stall_cnt;
  logic [7:0] w_stall_cnt_next;
  logic       r_stall_err;

  always_comb begin
    w_stall_cnt_next = r_stall_cnt;
    if (w_transfer) begin
      w_stall_cnt_next = '0;
    end else if ((r_state == StFull) && arb_bus.buffer_full && (r_stall_cnt != 8'hFF)) begin
      w_stall_cnt_next = r_stall_cnt + 8'd1;
    end
  end

  // Error flags on the same edge the count reaches the limit and is sticky until reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_next;
      if (32'(w_stall_cnt_next) >= MAX_STALL) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign arb_bus.stall_cnt = r_stall_cnt;
  assign arb_bus.stall_err = r_stall_err;
`else
  assign arb_bus.stall_cnt = '0;
  assign arb_bus.stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Scoreboard bench for phy_tx_arbiter: a reference model predicts grants, held flit and
// stall state each cycle; granted flits are queued and popped as the PHY accepts them.
module tb_phy_tx_arbiter;
  import chiplet_types_pkg::*;

  localparam int unsigned NumReq   = 4;
  localparam int unsigned MaxStall = 10;
`ifdef PHY_TX_ARB_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  phy_tx_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  phy_tx_arbiter #(
    .NUM_REQ  (NumReq),
    .MAX_STALL(MaxStall)
  ) dut (
    .CLK    (clk),
    .nRST   (nrst),
    .arb_bus(bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  flit_t       exp_q[$];
  logic        m_valid;
  int          m_ptr;
  logic [7:0]  m_cnt;
  logic        m_err;
  int unsigned seq [NumReq];
  int          obs_g;
  int          exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic flit_t mk_flit(input int r, input int unsigned s);
    return {4'hA, 4'(r), 24'(s)};
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model
  // to what the coming posedge will do.
  task automatic run_cycle(input logic rst_n, input logic [NumReq-1:0] v, input logic bf);
    logic [NumReq-1:0] exp_gnt;
    int                g;
    int                idx;
    logic              xfer;
    @(negedge clk);
    nrst            = rst_n;
    bus.req_valid   = v;
    bus.buffer_full = bf;
    for (int i = 0; i < NumReq; i++) bus.req_flit[i] = mk_flit(i, seq[i]);
    #1;
    xfer    = m_valid && !bf;
    exp_gnt = '0;
    g       = -1;
    if (rst_n && (!m_valid || xfer)) begin
      for (int k = 0; k < NumReq; k++) begin
        idx = (m_ptr + k) % NumReq;
        if (g < 0 && v[2'(idx)]) g = idx;
      end
    end
    if (g >= 0) exp_gnt[2'(g)] = 1'b1;
    obs_g = -1;
    for (int j = 0; j < NumReq; j++) if (bus.req_ready[2'(j)]) obs_g = j;

    check_eq("data_ready", bus.data_ready, m_valid);
    if (m_valid) check_eq("flit", bus.flit, exp_q[0]);
    check_eq("req_ready", bus.req_ready, exp_gnt);
    check_eq("stall_cnt", bus.stall_cnt, m_cnt);
    check_eq("stall_err", bus.stall_err, m_err);

    if (!rst_n) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_cnt   = '0;
      m_err   = 1'b0;
      exp_q.delete();
    end else begin
      if (StallEn) begin
        if (xfer) m_cnt = '0;
        else if (m_valid && bf && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (32'(m_cnt) >= MaxStall) m_err = 1'b1;
      end
      if (xfer) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(mk_flit(g, seq[g]));
        seq[g]++;
        m_ptr   = (g + 1) % NumReq;
        m_valid = 1'b1;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    nrst            = 1'b0;
    bus.req_valid   = '0;
    bus.buffer_full = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      bus.req_flit[i] = '0;
      seq[i]          = 0;
    end
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = '0;
    m_err   = 1'b0;

    // Reset held with all requesters asking.
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b0, 4'hF, 1'b0);
      if (c > 0) check_eq("rst_flit", bus.flit, 64'h0);
    end

    // Round-robin at full throughput.
    for (int c = 0; c < 5; c++) begin
      run_cycle(1'b1, 4'hF, 1'b0);
      check_eq("rr_order", obs_g, exp_order[c]);
    end

    // Backpressure while FULL, then release: transfer and reload on the same edge.
    for (int c = 0; c < 5; c++) run_cycle(1'b1, 4'hF, 1'b1);
    run_cycle(1'b1, 4'hF, 1'b0);
    check_eq("bp_reload", obs_g, 1);

    // Sparse request with the pointer at the top requester.
    for (int c = 0; c < 8 && m_ptr != 3; c++) run_cycle(1'b1, 4'hF, 1'b0);
    run_cycle(1'b1, 4'b0010, 1'b0);
    check_eq("sparse_grant", obs_g, 1);
    run_cycle(1'b1, 4'hF, 1'b0);
    check_eq("sparse_ptr", obs_g, 2);

    // Idle drain leaves the pointer alone.
    for (int c = 0; c < 4; c++) run_cycle(1'b1, 4'h0, 1'b0);
    run_cycle(1'b1, 4'hF, 1'b0);
    check_eq("idle_ptr", obs_g, 3);

`ifdef PHY_TX_ARB_STALL_EN
    for (int c = 0; c < 12; c++) run_cycle(1'b1, 4'hF, 1'b1);
    run_cycle(1'b1, 4'hF, 1'b0);
    check_eq("stall_err_set", bus.stall_err, 1'b1);
    run_cycle(1'b1, 4'hF, 1'b0);
    check_eq("stall_err_hold", bus.stall_err, 1'b1);
    check_eq("stall_cnt_clr", bus.stall_cnt, 8'd0);
`endif

    // Random traffic and backpressure.
    for (int c = 0; c < 300; c++) begin
      run_cycle(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    // Reset while FULL and stalled: held flit must be dropped.
    run_cycle(1'b1, 4'hF, 1'b1);
    run_cycle(1'b1, 4'hF, 1'b1);
    run_cycle(1'b0, 4'hF, 1'b1);
    run_cycle(1'b1, 4'h0, 1'b0);
    check_eq("mid_rst_dr", bus.data_ready, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(1'b1, 4'h0, 1'b0);
    run_cycle(1'b1, 4'hF, 1'b0);
    check_eq("mid_rst_grant", obs_g, 0);
    run_cycle(1'b1, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
